i2c_xlate_master: RTL and testbench
===================================

Name: i2c_xlate_master

Overview:
- Parametrised I2C address-translating master. Generalises the fixed two-slave translator to NUM_CH channels with a runtime-programmable map.
- Accepts single-byte read/write requests on a virtual 7-bit address and translates it to a physical address through a table.
- Runs the full I2C sequence (START, addr+RW, data, ACK, STOP) on open-drain SCL/SDA and returns data plus status.
- Sits between the system request logic and the I2C pads. Replaces the hard-wired Slave_sel/rw stimulus path.

Parameters:
- NUM_CH, 4, number of translated channels (1..16); IDXW = max(1, clog2(NUM_CH)).
- VADDR_BASE, 7'h50, first virtual address; channel i is VADDR_BASE+i.
- PADDR_RST, 7'h20, reset map value; map[i] = PADDR_RST+i.
- CLK_DIV, 250, ref_clk cycles per SCL quarter-period tick (>=2).

Ports:
- ref_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_rw  in  1  0 = write, 1 = read.
- req_vaddr  in  7  virtual address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle response pulse (txn_done).
- rsp_rdata  out  8  read byte; 0 for writes and errors.
- rsp_err  out  2  0 ok, 1 unmapped, 2 address NACK, 3 data NACK.
- cfg_we  in  1  map write enable.
- cfg_idx  in  IDXW  map entry index.
- cfg_paddr  in  7  physical address to store.
- scl_oe  out  1  1 = drive SCL low, 0 = release.
- sda_oe  out  1  1 = drive SDA low, 0 = release.
- sda_i  in  1  SDA pad input (sync by 2 flops internally).

Behaviour:
- Async reset: scl_oe=0, sda_oe=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, map[i]=PADDR_RST+i, state IDLE, tick counter 0.
- Reset mid-transaction releases both lines immediately. No STOP is generated and no response is issued.
- Accept on req_valid && req_ready. The request is latched and the map is read at accept; later cfg writes do not affect an in-flight transaction.
- cfg_we is honoured in any state. cfg_idx >= NUM_CH is ignored.
- Translation: vaddr in [VADDR_BASE, VADDR_BASE+NUM_CH-1] gives paddr = map[vaddr-VADDR_BASE]. Otherwise the block goes to DONE with no bus activity and rsp_err=1; rsp_valid is asserted 1 cycle after accept.
- Tick counter runs only outside IDLE/DONE, pulsing every CLK_DIV cycles. Each bit occupies quarters q0..q3:
  - q0, q1: SCL low.
  - q2, q3: SCL released.
  - SDA changes only at q0.
  - sda_i is sampled at the q2->q3 tick.
- States and transitions:
  - IDLE -> START.
  - START: q0/q1 both lines released; q2 SDA low; q3 SDA held low with SCL high.
  - START -> ADDR: 8 bits, {paddr, rw}, MSB first.
  - ADDR -> AACK: SDA released; sampled 1 means NACK -> STOP with err=2.
  - AACK -> WDATA (8 bits) -> WACK (sampled 1 -> err=3) -> STOP; or
  - AACK -> RDATA: SDA released, shift in MSB first -> MNACK (master releases SDA = NACK) -> STOP.
  - STOP: q0/q1 SCL low, SDA low; q2 SCL released; q3 SDA released.
  - STOP -> DONE.
  - DONE: rsp_valid=1 for one cycle with rsp_err/rsp_rdata valid -> IDLE. req_ready=1 on the cycle after the pulse.
- Transaction length, accept to rsp_valid: 80*CLK_DIV+1 cycles for reads and writes. Address NACK: 48*CLK_DIV+1.
- rsp_rdata and rsp_err hold until the next response.
- No clock stretching and no arbitration. SCL is never sampled.

Test Plan:
- Write: defaults, CLK_DIV=4, vaddr 7'h51, wdata 8'hA5, slave model ACKs. Required: bus shows START, byte 8'h42 (7'h21<<1 | 0), then 8'hA5, then STOP; rsp_valid at cycle 321 after accept; rsp_err=0.
- Read: vaddr 7'h53, slave returns 8'h3C. Required: address byte 8'h47, rsp_rdata=8'h3C, master NACK on the 9th bit, err=0.
- Remap: cfg_we idx=2, paddr=7'h68, then write to vaddr 7'h52. Required: address byte 8'hD0. Same cfg write during an in-flight txn to 7'h52 must leave that txn using 7'h22.
- Errors:
  - vaddr 7'h10: scl_oe and sda_oe stay 0; rsp_err=1 one cycle after accept.
  - No slave ACK: rsp_err=2 after 193 cycles, STOP present.
  - Data NACK: rsp_err=3.
- Reset mid-ADDR: both oe drop to 0 asynchronously, no rsp_valid, req_ready=1, map returns to 7'h20..7'h23.
- Back-to-back: req_valid held with 4 queued requests. Required: exactly 4 rsp_valid pulses, and req_ready is low throughout each transaction.

Source files
------------

// File: rtl/i2c_xlate_master.sv
// Single-byte I2C master that maps a virtual 7-bit address onto a physical
// one through a runtime-programmable channel table.
module i2c_xlate_master #(
  parameter int         NUM_CH     = 4,
  parameter int         IDXW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [6:0] VADDR_BASE = 7'h50,
  parameter logic [6:0] PADDR_RST  = 7'h20,
  parameter int         CLK_DIV    = 250
) (
  input  logic            ref_clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_rw,
  input  logic [6:0]      req_vaddr,
  input  logic [7:0]      req_wdata,
  output logic            rsp_valid,
  output logic [7:0]      rsp_rdata,
  output logic [1:0]      rsp_err,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [6:0]      cfg_paddr,
  output logic            scl_oe,
  output logic            sda_oe,
  input  logic            sda_i
);

  localparam int CNTW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK,
    S_RDATA, S_MNACK, S_PAD, S_STOP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      q_q, q_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      rx_q, rx_d;
  logic            ack_q, ack_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [1:0]      err_q, err_d;
  logic [6:0]      map_q [NUM_CH];
  logic [6:0]      map_d [NUM_CH];
  logic            scl_oe_q, scl_oe_d;
  logic            sda_oe_q, sda_oe_d;
  logic            sda_s1_q, sda_s2_q;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_err_q, rsp_err_d;

  logic       tick, last, accept, hit;
  logic [6:0] off;

  // Line drive per state/quarter: {scl_oe, sda_oe}; b is the data bit.
  function automatic logic [1:0] drive(state_t s, logic [1:0] q, logic b);
    logic lo;
    lo = ~q[1];
    unique case (s)
      S_START:                          drive = {1'b0, q[1]};
      S_ADDR, S_WDATA:                  drive = {lo, ~b};
      S_AACK, S_WACK, S_RDATA, S_MNACK: drive = {lo, 1'b0};
      S_PAD:                            drive = 2'b10;
      S_STOP:                           drive = {lo, q != 2'd3};
      default:                          drive = 2'b00;
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE) && !rsp_valid_q;
  assign accept    = req_valid && req_ready;
  assign off       = req_vaddr - VADDR_BASE;
  assign hit       = (req_vaddr >= VADDR_BASE) && (int'(off) < NUM_CH);

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    ack_d       = ack_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    map_d       = map_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tick        = 1'b0;

    if (cfg_we && int'(cfg_idx) < NUM_CH) map_d[cfg_idx] = cfg_paddr;

    if (state_q == S_IDLE || state_q == S_DONE) begin
      cnt_d = '0;
    end else if (cnt_q == CNTW'(CLK_DIV - 1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNTW'(1);
    end

    if (tick) begin
      q_d = q_q + 2'd1;
      if (q_q == 2'd2) begin
        ack_d = sda_s2_q;
        if (state_q == S_RDATA) rx_d = {rx_q[6:0], sda_s2_q};
      end
    end
    last = tick && (q_q == 2'd3);

    unique case (state_q)
      S_IDLE: if (accept) begin
        rw_d    = req_rw;
        wdata_d = req_wdata;
        sh_d    = {map_q[off[IDXW-1:0]], req_rw};
        bit_d   = 3'd0;
        q_d     = 2'd0;
        err_d   = hit ? 2'd0 : 2'd1;
        state_d = hit ? S_START : S_DONE;
      end
      S_START: if (last) state_d = S_ADDR;
      S_ADDR, S_WDATA: if (last) begin
        if (bit_q == 3'd7) begin
          bit_d   = 3'd0;
          state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
        end
      end
      S_AACK: if (last) begin
        bit_d = 3'd0;
        if (ack_q) begin
          err_d   = 2'd2;
          state_d = S_PAD;
        end else if (rw_q) begin
          state_d = S_RDATA;
        end else begin
          sh_d    = wdata_q;
          state_d = S_WDATA;
        end
      end
      S_WACK: if (last) begin
        if (ack_q) err_d = 2'd3;
        state_d = S_STOP;
      end
      S_RDATA: if (last) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_MNACK;
      end
      // PAD holds SCL low for one bit after an address NACK
      S_MNACK, S_PAD: if (last) state_d = S_STOP;
      S_STOP: if (last) state_d = S_DONE;
      S_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (rw_q && err_q == 2'd0) ? rx_q : 8'h00;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    {scl_oe_d, sda_oe_d} = drive(state_d, q_d, sh_d[7]);
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      ack_q       <= 1'b1;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      err_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) map_q[i] <= PADDR_RST + 7'(i);
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      ack_q       <= ack_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      map_q       <= map_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      sda_s1_q    <= sda_i;
      sda_s2_q    <= sda_s1_q;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_xlate_master.sv
// Bench for i2c_xlate_master: open-drain bus with a clocked slave model
// and a response scoreboard.
module tb_i2c_xlate_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [6:0] req_vaddr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [6:0] cfg_paddr = '0;
  logic       scl_oe, sda_oe;
  logic       sd;
  logic       scl_w, sda_w;

  always #5 clk = ~clk;

  assign scl_w = ~scl_oe;
  assign sda_w = ~(sda_oe | sd);

  i2c_xlate_master #(.CLK_DIV(4)) dut (
    .ref_clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_vaddr(req_vaddr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_paddr(cfg_paddr),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_w)
  );

  typedef struct {
    logic [1:0] err;
    logic [7:0] rdata;
    logic [7:0] abyte;
    logic [7:0] wbyte;
    logic       rw;
    int         acc;
    int         lat;
    int         starts;
    int         stops;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, n_rsp = 0, rdy_viol = 0;
  logic oe_any = 1'b0;
  logic [6:0] mdl_map [4];

  // slave model state
  logic       ack_addr = 1'b1, ack_data = 1'b1;
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] got_a = '0, got_w = '0, ssh = '0;
  logic       got_mn = 1'b0, srw = 1'b0, sok = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         n_start = 0, n_stop = 0, slot = 0, byte_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic map_reset();
    for (int i = 0; i < 4; i++) mdl_map[i] = 7'h20 + 7'(i);
  endtask

  // Slave: edge detection on the bus, sampled away from the DUT edge.
  initial begin
    sd = 1'b0;
    forever begin
      @(negedge clk);
      if (scl_w && scl_p && sda_p && !sda_w) begin
        n_start++;
        slot = -1;
        byte_no = 0;
        sok = 1'b0;
        sd = 1'b0;
      end else if (scl_w && scl_p && !sda_p && sda_w) begin
        n_stop++;
      end else if (scl_w && !scl_p) begin
        if (slot >= 0 && slot < 8) ssh = {ssh[6:0], sda_w};
        else if (slot == 8 && byte_no == 1 && srw) got_mn = sda_w;
      end else if (!scl_w && scl_p) begin
        slot++;
        if (slot == 9) begin
          slot = 0;
          byte_no++;
        end
        sd = 1'b0;
        if (slot == 8 && byte_no == 0) begin
          got_a = ssh;
          srw = ssh[0];
          sok = ack_addr;
          sd = ack_addr;
        end else if (slot == 8 && byte_no == 1 && !srw) begin
          got_w = ssh;
          sd = ack_data;
        end else if (byte_no == 1 && srw && sok && slot < 8) begin
          sd = ~rd_byte[3'(7 - slot)];
        end
      end
      scl_p = scl_w;
      sda_p = sda_w;
    end
  end

  // Response monitor / scoreboard pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      oe_any = oe_any | scl_oe | sda_oe;
      if (exp_q.size() > 0 && req_ready) rdy_viol++;
      if (rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check("rsp_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("latency", cyc - e.acc, e.lat);
          if (e.err == 2'd1) begin
            check("no_bus", 32'(oe_any), 32'd0);
          end else begin
            check("addr_byte", 32'(got_a), 32'(e.abyte));
            check("start_seen", n_start - e.starts, 1);
            check("stop_seen", n_stop - e.stops, 1);
            if (!e.rw && e.err != 2'd2)
              check("data_byte", 32'(got_w), 32'(e.wbyte));
            if (e.rw && e.err == 2'd0)
              check("master_nack", 32'(got_mn), 32'd1);
          end
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge past accept.
  task automatic send(input logic rw, input logic [6:0] va,
                      input logic [7:0] wd, input logic hold);
    exp_t e;
    int n;
    logic hit;
    logic [6:0] pa;
    req_valid = 1'b1;
    req_rw    = rw;
    req_vaddr = va;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    hit = (va >= 7'h50) && (va < 7'h54);
    pa = hit ? mdl_map[2'(va - 7'h50)] : 7'h00;
    e.rw = rw;
    e.abyte = {pa, rw};
    e.wbyte = wd;
    e.err = !hit ? 2'd1 : !ack_addr ? 2'd2 :
            (!rw && !ack_data) ? 2'd3 : 2'd0;
    e.rdata = (rw && e.err == 2'd0) ? rd_byte : 8'h00;
    e.lat = (e.err == 2'd1) ? 1 : (e.err == 2'd2) ? 193 : 321;
    e.acc = cyc + 1;
    e.starts = n_start;
    e.stops = n_stop;
    @(posedge clk);
    exp_q.push_back(e);
    oe_any = 1'b0;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("idle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [1:0] idx, input logic [6:0] pa);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_paddr = pa;
    @(negedge clk);
    cfg_we = 1'b0;
    mdl_map[idx] = pa;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, r0;
    map_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(1'b0, 7'h51, 8'hA5, 1'b0);
    wait_idle();
    rd_byte = 8'h3C;
    send(1'b1, 7'h53, 8'h00, 1'b0);
    wait_idle();

    send(1'b0, 7'h52, 8'h11, 1'b0);
    repeat (20) @(negedge clk);
    cfg_wr(2'd2, 7'h68);
    wait_idle();
    send(1'b0, 7'h52, 8'h77, 1'b0);
    wait_idle();

    send(1'b0, 7'h10, 8'h55, 1'b0);
    wait_idle();
    check("err_hold", 32'(rsp_err), 32'd1);

    ack_addr = 1'b0;
    send(1'b0, 7'h50, 8'h99, 1'b0);
    wait_idle();
    ack_addr = 1'b1;
    ack_data = 1'b0;
    send(1'b0, 7'h51, 8'h5A, 1'b0);
    wait_idle();
    ack_data = 1'b1;

    s0 = n_start;
    send(1'b0, 7'h51, 8'hC3, 1'b0);
    n = 0;
    while (!(n_start > s0 && scl_oe) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    map_reset();
    #1;
    check("async_scl_oe", 32'(scl_oe), 32'd0);
    check("async_sda_oe", 32'(sda_oe), 32'd0);
    r0 = n_rsp;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    repeat (400) @(negedge clk);
    check("no_rsp_after_rst", n_rsp - r0, 0);
    send(1'b0, 7'h52, 8'h3E, 1'b0);
    wait_idle();
    rd_byte = 8'hE7;
    send(1'b1, 7'h50, 8'h00, 1'b0);
    wait_idle();

    r0 = n_rsp;
    rdy_viol = 0;
    rd_byte = 8'h81;
    send(1'b0, 7'h50, 8'h01, 1'b1);
    send(1'b1, 7'h51, 8'h00, 1'b1);
    send(1'b0, 7'h52, 8'hFE, 1'b1);
    send(1'b1, 7'h53, 8'h00, 1'b1);
    req_valid = 1'b0;
    wait_idle();
    check("b2b_rsp_count", n_rsp - r0, 4);
    check("ready_low_busy", rdy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
